// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with input qualifier, synchronous clear and registered pulse.
// Optional saturating match counter compiled in with `define SEQ_MATCH_CNT_EN.
module seq_detect_param #(
    parameter int unsigned PAT_LEN = 5,
    parameter logic [31:0] PATTERN = 32'b10010,
    parameter bit          REPEAT  = 1'b1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             data_en,
    input  logic             data_in,
    output logic             data_out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN);
    localparam logic [PAT_LEN-1:0] PAT      = PATTERN[PAT_LEN-1:0];

    if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
        $error("seq_detect_param: PAT_LEN=%0d outside legal range 2..32", PAT_LEN);
    end

    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_out;

    logic [PAT_LEN-1:0] w_next_hist;
    logic [FILL_W-1:0]  w_next_fill;
    logic               w_hit;

    always_comb begin
        w_next_hist = {r_hist[PAT_LEN-2:0], data_in};
        w_next_fill = (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
        // Fill gating keeps reset zeros from matching an all-zero pattern.
        w_hit       = (w_next_fill == FILL_MAX) && (w_next_hist == PAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (clr) begin
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (data_en) begin
            r_hist <= w_next_hist;
            r_out  <= w_hit;
            // Non-overlapping mode demands a full set of fresh bits after each match.
            if (!REPEAT && w_hit) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_next_fill;
            end
        end else begin
            r_out <= 1'b0;
        end
    end

    assign data_out = r_out;

`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (data_en && w_hit && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_cnt = r_cnt;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four instances cover default, non-overlapping,
// all-zero pattern and counter-saturation configurations on shared stimulus.
module tb_seq_detect_param;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       data_en;
    logic       data_in;

    logic       def_out, nr_out, z_out, s_out;
    logic [7:0] def_cnt, nr_cnt, z_cnt;
    logic [1:0] s_cnt;

    int total;
    int bad;
    int cnt_on;

    seq_detect_param u_def (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_en(data_en), .data_in(data_in),
        .data_out(def_out), .match_cnt(def_cnt)
    );

    seq_detect_param #(.REPEAT(1'b0)) u_norep (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_en(data_en), .data_in(data_in),
        .data_out(nr_out), .match_cnt(nr_cnt)
    );

    seq_detect_param #(.PAT_LEN(3), .PATTERN(32'b000), .REPEAT(1'b1)) u_zero (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_en(data_en), .data_in(data_in),
        .data_out(z_out), .match_cnt(z_cnt)
    );

    seq_detect_param #(.PAT_LEN(2), .PATTERN(32'b11), .REPEAT(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_en(data_en), .data_in(data_in),
        .data_out(s_out), .match_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs on the falling edge, return 1 time unit after the sampling edge.
    task automatic drive(input logic c, input logic en, input logic d);
        @(negedge clk);
        clr     = c;
        data_en = en;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        clr     = 1'b0;
        data_en = 1'b0;
        data_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        clr     = 1'b0;
        data_en = 1'b0;
        data_in = 1'b0;
        #1;
        total++;
        if ({def_out, nr_out, z_out, s_out} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_out: got %b want 0000", {def_out, nr_out, z_out, s_out});
        end
        total++;
        if (def_cnt !== 8'd0 || nr_cnt !== 8'd0 || z_cnt !== 8'd0 || s_cnt !== 2'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d/%0d want 0", def_cnt, nr_cnt, z_cnt, s_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_repeat();
        logic bits   [8];
        logic exp_d  [8];
        logic exp_nr [8];
        int   exp_c;
        bits   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_d  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_nr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, bits[i]);
            total++;
            if (def_out !== exp_d[i]) begin
                bad++;
                $display("FAIL overlap bit%0d: got %b want %b", i + 1, def_out, exp_d[i]);
            end
            total++;
            if (nr_out !== exp_nr[i]) begin
                bad++;
                $display("FAIL nonoverlap bit%0d: got %b want %b", i + 1, nr_out, exp_nr[i]);
            end
        end
        exp_c = cnt_on ? 2 : 0;
        total++;
        if (def_cnt !== 8'(exp_c)) begin
            bad++;
            $display("FAIL overlap_cnt: got %0d want %0d", def_cnt, exp_c);
        end
        exp_c = cnt_on ? 1 : 0;
        total++;
        if (nr_cnt !== 8'(exp_c)) begin
            bad++;
            $display("FAIL nonoverlap_cnt: got %0d want %0d", nr_cnt, exp_c);
        end
    endtask

    task automatic test_stall();
        logic en  [9];
        logic d   [9];
        logic exp [9];
        en  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        d   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, en[i], d[i]);
            total++;
            if (def_out !== exp[i]) begin
                bad++;
                $display("FAIL stall step%0d: got %b want %b", i, def_out, exp[i]);
            end
        end
    endtask

    task automatic test_zero_pattern();
        logic exp_z [6];
        exp_z = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            total++;
            if (z_out !== exp_z[i]) begin
                bad++;
                $display("FAIL zero_pat bit%0d: got %b want %b", i + 1, z_out, exp_z[i]);
            end
            total++;
            if (def_out !== 1'b0) begin
                bad++;
                $display("FAIL zero_stream_def bit%0d: got %b want 0", i + 1, def_out);
            end
        end
    endtask

    task automatic test_clr();
        logic c   [11];
        logic d   [11];
        logic exp [11];
        c   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        d   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            drive(c[i], 1'b1, d[i]);
            total++;
            if (def_out !== exp[i]) begin
                bad++;
                $display("FAIL clr step%0d: got %b want %b", i, def_out, exp[i]);
            end
        end
    endtask

    task automatic test_saturate();
        int exp_c;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            total++;
            if (s_out !== (i > 0)) begin
                bad++;
                $display("FAIL sat_out bit%0d: got %b want %b", i + 1, s_out, (i > 0));
            end
            exp_c = cnt_on ? ((i > 3) ? 3 : i) : 0;
            total++;
            if (s_cnt !== 2'(exp_c)) begin
                bad++;
                $display("FAIL sat_cnt bit%0d: got %0d want %0d", i + 1, s_cnt, exp_c);
            end
        end
        drive(1'b1, 1'b1, 1'b1);
        total++;
        if (s_cnt !== 2'd0 || s_out !== 1'b0) begin
            bad++;
            $display("FAIL sat_clr: got cnt=%0d out=%b want cnt=0 out=0", s_cnt, s_out);
        end
        drive(1'b0, 1'b1, 1'b1);
        total++;
        if (s_out !== 1'b0) begin
            bad++;
            $display("FAIL sat_refill: got %b want 0", s_out);
        end
        drive(1'b0, 1'b1, 1'b1);
        exp_c = cnt_on ? 1 : 0;
        total++;
        if (s_out !== 1'b1 || s_cnt !== 2'(exp_c)) begin
            bad++;
            $display("FAIL sat_rematch: got out=%b cnt=%0d want out=1 cnt=%0d", s_out, s_cnt,
                     exp_c);
        end
    endtask

    task automatic test_mid_reset();
        logic bits [5];
        bits = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, bits[i]);
        total++;
        if (def_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_pre: got %b want 1", def_out);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (def_out !== 1'b0 || def_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: got out=%b cnt=%0d want 0/0", def_out, def_cnt);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, bits[i]);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        total++;
        if (def_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_partial: got %b want 0", def_out);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
`ifdef SEQ_MATCH_CNT_EN
        cnt_on  = 1;
`else
        cnt_on  = 0;
`endif
        rst_n   = 1'b1;
        clr     = 1'b0;
        data_en = 1'b0;
        data_in = 1'b0;
        test_reset();
        test_repeat();
        test_stall();
        test_zero_pattern();
        test_clr();
        test_saturate();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector; the successor to the fixed 10010 Moore detector.
- Pattern length, pattern value and overlap mode are set by parameters.
- Adds an input qualifier, a synchronous clear and an optional saturating match counter.
- Sits on a 1-bit serial data path and reports each detected pattern as a single-cycle registered pulse.

Parameters:
PAT_LEN, 5, pattern length in bits; legal range 2..32
PATTERN, 32'b10010, pattern value; only bits [PAT_LEN-1:0] are used; bit PAT_LEN-1 is the first bit received
REPEAT, 1'b1, 1 = overlapping detection (repeat); 0 = non-overlapping detection
CNT_W, 8, match counter width; used only when the optional feature is compiled in

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of the detector state
data_en  input  1  qualifies data_in; data_in is sampled only when data_en=1
data_in  input  1  serial data bit
data_out  output  1  registered match pulse
match_cnt  output  CNT_W  saturating match count; driven 0 when the feature is compiled out

Behaviour:
- State:
  - hist[PAT_LEN-1:0] shift register; the newest bit enters at bit 0.
  - fill counter of valid history bits, width $clog2(PAT_LEN+1), saturating at PAT_LEN.
  - data_out register.
  - match_cnt register.
- Reset (rst_n=0, asynchronous): hist=0, fill=0, data_out=0, match_cnt=0.
- Priority per edge: clr, then data_en, then idle.
- clr=1: hist, fill, data_out and match_cnt all go to 0 on the next edge. A data_in bit in the same cycle is discarded.
- data_en=1, clr=0:
  - next_hist = {hist[PAT_LEN-2:0], data_in}.
  - next_fill = min(fill+1, PAT_LEN).
  - hit = (next_fill==PAT_LEN) && (next_hist==PATTERN[PAT_LEN-1:0]).
  - data_out <= hit.
  - REPEAT=1: hist <= next_hist and fill <= next_fill, so overlapping matches are detected.
  - REPEAT=0 and hit: fill <= 0 (hist is still updated). A new match therefore needs PAT_LEN fresh bits.
- data_en=0, clr=0: hist and fill hold; data_out <= 0.
- Latency: data_out is high for exactly the one cycle after the edge that samples the final pattern bit.
  - Back-to-back pulses are possible only with REPEAT=1 and a self-overlapping pattern (e.g. all-ones).
- Matching starts only once PAT_LEN bits have been sampled since reset or clr. Reset zeros in hist must never produce a false match, including for an all-zero PATTERN.
- Gaps in data_en do not break a partial match: the history simply stalls.
- Reset asserted mid-sequence clears all state; a partial pattern must not complete afterwards.
- Static check: PAT_LEN outside 2..32 is a configuration error, flagged by an elaboration-time $error.

Optional Feature:
- Macro: SEQ_MATCH_CNT_EN.
- Defined:
  - match_cnt increments by 1 on each edge where data_out is set to 1.
  - It saturates at 2^CNT_W-1 and never wraps.
  - It is cleared by rst_n and by clr.
- Undefined: no counter register exists; match_cnt is tied to 0 and the port list is unchanged.

Test Plan:
- Defaults, REPEAT=1, data_en=1, stream 1,0,0,1,0,0,1,0 -> data_out pulses the cycle after bit 5 and the cycle after bit 8; match_cnt=2 (feature on).
- Same stream with REPEAT=0 -> single pulse after bit 5; match_cnt=1.
- Defaults, stream 1,0,0,1,0 with data_en=0 for 3 cycles between bits 3 and 4 -> one pulse after bit 5; data_out=0 during the stall cycles.
- PAT_LEN=3, PATTERN=3'b000, REPEAT=1, zeros from reset -> first pulse after the 3rd sampled bit, not before; then one pulse every cycle.
- Defaults, clr asserted after bits 1,0,0,1, then 0 -> no pulse; a full 10010 afterwards -> pulse.
- CNT_W=2, feature on, all-ones pattern PAT_LEN=2, 10 ones -> match_cnt saturates at 3; clr -> match_cnt=0 next cycle.
